// File: rtl/blockade_pkg.sv
// Shared definitions for the Blockade/CoMotion/Hustle/Blasto sound path:
// playback state encoding, default sample rate and per-game ROM windows.
package blockade_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2,
    TAIL  = 2'd3
  } play_state_e;

  // 20 MHz / 1814 ~= 11.025 kHz sample rate
  localparam int SAMPLE_CLK_DIV = 1814;

  // Crash-sound windows inside the shared 64 KiB PCM ROM, one per game
  localparam logic [15:0] BLOCKADE_SAMPLE_START = 16'h0000;
  localparam logic [15:0] BLOCKADE_SAMPLE_END   = 16'h3FFF;
  localparam logic [15:0] COMOTION_SAMPLE_START = 16'h4000;
  localparam logic [15:0] COMOTION_SAMPLE_END   = 16'h7FFF;
  localparam logic [15:0] HUSTLE_SAMPLE_START   = 16'h8000;
  localparam logic [15:0] HUSTLE_SAMPLE_END     = 16'hBFFF;
  localparam logic [15:0] BLASTO_SAMPLE_START   = 16'hC000;
  localparam logic [15:0] BLASTO_SAMPLE_END     = 16'hFFFF;

  // Offset-binary 8-bit PCM to signed 16-bit: flip the MSB, left-justify
  function automatic logic [15:0] pcm_to_audio(input logic [7:0] d);
    return {~d[7], d[6:0], 8'h00};
  endfunction

endpackage

// File: rtl/blockade_rate_div.sv
// Sample-rate divider: one-cycle tick every CLK_DIV enabled cycles.
// clr_i restarts the period from zero and wins over en_i.
module blockade_rate_div
  import blockade_pkg::*;
#(
  parameter int CLK_DIV = SAMPLE_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear, wrap on terminal count, or advance when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blockade_sample_player.sv
// Crash-sound sample player: on a trigger rising edge, streams the PCM
// window SAMPLE_START..SAMPLE_END from the sound ROM as signed 16-bit audio,
// one sample per CLK_DIV clocks. Define SAMPLE_LOOP_EN to keep looping the
// sample for as long as the trigger stays high.
//
// state | meaning
// IDLE  | silent, rom_addr parked on SAMPLE_START, waiting for a trigger edge
// PRIME | one cycle for the ROM to deliver the first sample
// PLAY  | emitting a new sample on every divider tick
// TAIL  | holding the last sample for one more period before going silent
module blockade_sample_player
  import blockade_pkg::*;
#(
  parameter int          CLK_DIV      = SAMPLE_CLK_DIV,
  parameter logic [15:0] SAMPLE_START = 16'h0000,
  parameter logic [15:0] SAMPLE_END   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger_i,
  input  logic        stop_i,
  output logic [15:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic [15:0] audio_o,
  output logic        busy_o
);

  play_state_e state_q;
  logic        trig_last_q;
  logic [15:0] addr_q;
  logic [15:0] audio_q;
  logic        busy_q;

  logic trig_edge;
  logic div_clr;
  logic div_en;
  logic tick;

  assign trig_edge = trigger_i && !trig_last_q;
  // Every restart point (stop, new edge, first emission) begins a fresh period
  assign div_clr   = stop_i || trig_edge || (state_q == PRIME);
  assign div_en    = (state_q == PLAY) || (state_q == TAIL);

  blockade_rate_div #(
    .CLK_DIV (CLK_DIV)
  ) u_rate_div (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (div_clr),
    .en_i   (div_en),
    .tick_o (tick)
  );

  // Playback FSM with registered outputs; reset > stop > edge > state action
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_last_q <= 1'b0;
      state_q     <= IDLE;
      addr_q      <= SAMPLE_START;
      audio_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      trig_last_q <= trigger_i;
      if (stop_i) begin
        state_q <= IDLE;
        addr_q  <= SAMPLE_START;
        audio_q <= '0;
        busy_q  <= 1'b0;
      end else if (trig_edge) begin
        state_q <= PRIME;
        addr_q  <= SAMPLE_START;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            audio_q <= '0;
          end
          PRIME: begin
            audio_q <= pcm_to_audio(rom_data_i);
            if (addr_q == SAMPLE_END) begin
              state_q <= TAIL;
            end else begin
              addr_q  <= addr_q + 16'd1;
              state_q <= PLAY;
            end
          end
          PLAY: begin
            if (tick) begin
              audio_q <= pcm_to_audio(rom_data_i);
              // End address is checked before incrementing, so no wrap
              if (addr_q == SAMPLE_END) begin
                state_q <= TAIL;
              end else begin
                addr_q <= addr_q + 16'd1;
              end
            end
          end
          TAIL: begin
            if (tick) begin
`ifdef SAMPLE_LOOP_EN
              // Last sample has had its full period; restart while held
              if (trigger_i) begin
                addr_q  <= SAMPLE_START;
                state_q <= PRIME;
              end else begin
`else
              begin
`endif
                audio_q <= '0;
                busy_q  <= 1'b0;
                addr_q  <= SAMPLE_START;
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr_o = addr_q;
  assign audio_o    = audio_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_blockade_sample_player.sv
// Directed bench for blockade_sample_player with CLK_DIV=4 and a
// three-byte sample at 0x0010..0x0012 (FF, 80, 00).
module tb_blockade_sample_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic        stop;
  logic [7:0]  rom_data;
  logic [15:0] rom_addr;
  logic [15:0] audio;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [15:0] max_addr = 16'h0000;

  always #5 clk = ~clk;

  blockade_sample_player #(
    .CLK_DIV      (4),
    .SAMPLE_START (16'h0010),
    .SAMPLE_END   (16'h0012)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger_i  (trigger),
    .stop_i     (stop),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .audio_o    (audio),
    .busy_o     (busy)
  );

  function automatic logic [7:0] rom_read(input logic [15:0] a);
    case (a)
      16'h0010: return 8'hFF;
      16'h0011: return 8'h80;
      16'h0012: return 8'h00;
      default:  return 8'h5A;
    endcase
  endfunction

  // ROM answers within the cycle: data for the registered address is ready
  // before the next rising edge.
  always @(negedge clk) rom_data <= rom_read(rom_addr);

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rom_addr > max_addr) max_addr = rom_addr;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; trigger = 1'b0; stop = 1'b0;
    step(3);
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL reset_audio got=%h exp=0000", audio); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (rom_addr !== 16'h0010) begin fails++; $display("FAIL reset_addr got=%h exp=0010", rom_addr); end
    reset = 1'b0;
    step(3);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
  endtask

  task automatic test_playback;
    max_addr = 16'h0000;
    trigger = 1'b1;                      // cycle T
    step(1);                             // T+1
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL play_busy_t1 got=%b exp=1", busy); end
    tests++; if (rom_addr !== 16'h0010) begin fails++; $display("FAIL play_addr_t1 got=%h exp=0010", rom_addr); end
    step(1);                             // T+2
    trigger = 1'b0;
    tests++; if (audio !== 16'h7F00) begin fails++; $display("FAIL play_s0_t2 got=%h exp=7f00", audio); end
    step(3);                             // T+5
    tests++; if (audio !== 16'h7F00) begin fails++; $display("FAIL play_s0_t5 got=%h exp=7f00", audio); end
    step(1);                             // T+6
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL play_s1_t6 got=%h exp=0000", audio); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL play_busy_t6 got=%b exp=1", busy); end
    step(4);                             // T+10
    tests++; if (audio !== 16'h8000) begin fails++; $display("FAIL play_s2_t10 got=%h exp=8000", audio); end
    step(3);                             // T+13, TAIL still holding
    tests++; if (audio !== 16'h8000 || busy !== 1'b1) begin fails++; $display("FAIL play_tail_t13 audio=%h busy=%b exp=8000/1", audio, busy); end
    step(1);                             // T+14
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL play_end_audio got=%h exp=0000", audio); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL play_end_busy got=%b exp=0", busy); end
    tests++; if (rom_addr !== 16'h0010) begin fails++; $display("FAIL play_end_addr got=%h exp=0010", rom_addr); end
    tests++; if (max_addr > 16'h0012) begin fails++; $display("FAIL addr_bound max=%h exp<=0012", max_addr); end
    step(2);
  endtask

  task automatic test_held_trigger;
    trigger = 1'b1;                      // T, held for the whole run
    step(14);                            // T+14
    tests++; if (busy !== 1'b0 || audio !== 16'h0000) begin fails++; $display("FAIL held_end busy=%b audio=%h exp=0/0000", busy, audio); end
    step(20);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_no_replay busy=%b exp=0", busy); end
    trigger = 1'b0;
    step(2);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_low busy=%b exp=0", busy); end
    trigger = 1'b1;
    step(1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL held_rearm busy=%b exp=1", busy); end
    step(1);
    tests++; if (audio !== 16'h7F00) begin fails++; $display("FAIL held_rearm_s0 got=%h exp=7f00", audio); end
    trigger = 1'b0;
    step(16);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_rearm_done busy=%b exp=0", busy); end
  endtask

  task automatic test_retrigger;
    trigger = 1'b1;                      // T
    step(1);
    trigger = 1'b0;
    step(5);                             // T+6, second sample in PLAY
    tests++; if (audio !== 16'h0000 || busy !== 1'b1) begin fails++; $display("FAIL retrig_pre audio=%h busy=%b exp=0000/1", audio, busy); end
    trigger = 1'b1;                      // new edge
    step(1);
    tests++; if (rom_addr !== 16'h0010) begin fails++; $display("FAIL retrig_prime_addr got=%h exp=0010", rom_addr); end
    tests++; if (audio !== 16'h0000 || busy !== 1'b1) begin fails++; $display("FAIL retrig_prime_hold audio=%h busy=%b exp=0000/1", audio, busy); end
    step(1);
    tests++; if (audio !== 16'h7F00) begin fails++; $display("FAIL retrig_s0 got=%h exp=7f00", audio); end
    tests++; if (rom_addr !== 16'h0011) begin fails++; $display("FAIL retrig_addr_next got=%h exp=0011", rom_addr); end
    trigger = 1'b0;
    step(4);
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL retrig_s1 got=%h exp=0000", audio); end
    step(12);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL retrig_done busy=%b exp=0", busy); end
  endtask

  task automatic test_stop;
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(5);                             // PLAY, second sample
    trigger = 1'b1; stop = 1'b1;         // stop and edge together
    step(1);
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL stop_audio got=%h exp=0000", audio); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy got=%b exp=0", busy); end
    tests++; if (rom_addr !== 16'h0010) begin fails++; $display("FAIL stop_addr got=%h exp=0010", rom_addr); end
    stop = 1'b0;
    step(3);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_edge_consumed busy=%b exp=0", busy); end
    trigger = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid_tail;
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(10);                            // T+11, TAIL
    tests++; if (audio !== 16'h8000 || busy !== 1'b1) begin fails++; $display("FAIL tail_pre audio=%h busy=%b exp=8000/1", audio, busy); end
    reset = 1'b1; trigger = 1'b1;
    step(1);
    tests++; if (audio !== 16'h0000 || busy !== 1'b0 || rom_addr !== 16'h0010) begin fails++; $display("FAIL tail_reset audio=%h busy=%b addr=%h exp=0000/0/0010", audio, busy, rom_addr); end
    step(2);
    trigger = 1'b0;
    step(1);
    reset = 1'b0;
    step(5);
    tests++; if (busy !== 1'b0 || audio !== 16'h0000) begin fails++; $display("FAIL tail_post_reset busy=%b audio=%h exp=0/0000", busy, audio); end
  endtask

  task automatic test_loop;
    trigger = 1'b1;                      // T, held
    step(2);                             // T+2
    tests++; if (audio !== 16'h7F00) begin fails++; $display("FAIL loop_p1_s0 got=%h exp=7f00", audio); end
    step(4);                             // T+6
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL loop_p1_s1 got=%h exp=0000", audio); end
    step(4);                             // T+10
    tests++; if (audio !== 16'h8000) begin fails++; $display("FAIL loop_p1_s2 got=%h exp=8000", audio); end
    step(4);                             // T+14, PRIME of second pass
    tests++; if (audio !== 16'h8000 || busy !== 1'b1 || rom_addr !== 16'h0010) begin fails++; $display("FAIL loop_prime audio=%h busy=%b addr=%h exp=8000/1/0010", audio, busy, rom_addr); end
    step(1);                             // T+15
    tests++; if (audio !== 16'h7F00) begin fails++; $display("FAIL loop_p2_s0 got=%h exp=7f00", audio); end
    step(4);                             // T+19
    tests++; if (audio !== 16'h0000) begin fails++; $display("FAIL loop_p2_s1 got=%h exp=0000", audio); end
    step(4);                             // T+23
    tests++; if (audio !== 16'h8000) begin fails++; $display("FAIL loop_p2_s2 got=%h exp=8000", audio); end
    step(1);                             // T+24
    trigger = 1'b0;
    step(2);                             // T+26
    tests++; if (audio !== 16'h8000 || busy !== 1'b1) begin fails++; $display("FAIL loop_tail audio=%h busy=%b exp=8000/1", audio, busy); end
    step(1);                             // T+27
    tests++; if (audio !== 16'h0000 || busy !== 1'b0) begin fails++; $display("FAIL loop_end audio=%h busy=%b exp=0000/0", audio, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; trigger = 1'b0; stop = 1'b0;
    test_reset();
    test_playback();
`ifdef SAMPLE_LOOP_EN
    test_loop();
`else
    test_held_trigger();
`endif
    test_retrigger();
    test_stop();
    test_reset_mid_tail();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
